// File: rtl/rvx_trap_unit_pkg.sv
// Shared definitions for the machine trap unit.
// Contents: core FSM state encodings, CSR addresses, trap cause codes,
// mstatus bit positions and the writable-bit mask for mie.
package rvx_trap_unit_pkg;

  typedef enum logic [3:0] {
    RVX_STATE_RESET       = 4'd0,
    RVX_STATE_OPERATING   = 4'd1,
    RVX_STATE_TRAP_TAKEN  = 4'd2,
    RVX_STATE_TRAP_RETURN = 4'd3
  } rvx_state_e;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  localparam logic [4:0] CAUSE_MISALIGNED_FETCH = 5'd0;
  localparam logic [4:0] CAUSE_ILLEGAL          = 5'd2;
  localparam logic [4:0] CAUSE_EBREAK           = 5'd3;
  localparam logic [4:0] CAUSE_MISALIGNED_LOAD  = 5'd4;
  localparam logic [4:0] CAUSE_MISALIGNED_STORE = 5'd6;
  localparam logic [4:0] CAUSE_ECALL            = 5'd11;
  localparam logic [4:0] CAUSE_IRQ_SOFTWARE     = 5'd3;
  localparam logic [4:0] CAUSE_IRQ_TIMER        = 5'd7;
  localparam logic [4:0] CAUSE_IRQ_EXTERNAL     = 5'd11;
  localparam logic [4:0] CAUSE_IRQ_FAST_BASE    = 5'd16;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;

  // Software, timer, external and the sixteen fast interrupt enables.
  localparam logic [31:0] MIE_WRITE_MASK = 32'hFFFF_0888;

endpackage

// File: rtl/rvx_trap_unit_if.sv
// CSR access bus of the trap unit.
// master: drives write strobe, address and write data, receives read data.
// slave : the trap unit; returns combinational read data of the addressed CSR.
interface rvx_trap_unit_if;
  logic        csr_write_enable;
  logic [11:0] csr_address;
  logic [31:0] csr_write_data;
  logic [31:0] csr_read_data;

  modport master (
    output csr_write_enable, csr_address, csr_write_data,
    input  csr_read_data
  );

  modport slave (
    input  csr_write_enable, csr_address, csr_write_data,
    output csr_read_data
  );
endinterface

// File: rtl/rvx_trap_unit_priority.sv
// Combinational trap priority encoder.
// Inputs : int_req_i (an enabled interrupt is pending and globally enabled),
//          per-source enabled-pending interrupt bits, stage-1 valid and
//          exception flags, pc/instruction/target address for mtval.
// Outputs: cause_o (full mcause value, bit 31 = interrupt), mtval_o.
module rvx_trap_unit_priority
  import rvx_trap_unit_pkg::*;
(
  input  logic        int_req_i,
  input  logic        irq_external_i,
  input  logic        irq_software_i,
  input  logic        irq_timer_i,
  input  logic [15:0] irq_fast_i,
  input  logic        valid_i,
  input  logic        misaligned_fetch_i,
  input  logic        illegal_instruction_i,
  input  logic        ebreak_i,
  input  logic        misaligned_load_i,
  input  logic        misaligned_store_i,
  input  logic        ecall_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] instruction_i,
  input  logic [31:0] target_address_i,
  output logic [31:0] cause_o,
  output logic [31:0] mtval_o
);

  logic [4:0] code;
  logic       interrupt;

  always_comb begin
    code      = 5'd0;
    interrupt = 1'b0;
    mtval_o   = 32'h0;
    if (int_req_i) begin
      // Interrupts always win and never carry an mtval.
      interrupt = 1'b1;
      if (irq_external_i)      code = CAUSE_IRQ_EXTERNAL;
      else if (irq_software_i) code = CAUSE_IRQ_SOFTWARE;
      else if (irq_timer_i)    code = CAUSE_IRQ_TIMER;
      else begin
        // Walk downwards so the lowest pending fast line is the last writer.
        for (int i = 15; i >= 0; i--) begin
          if (irq_fast_i[i]) code = CAUSE_IRQ_FAST_BASE + 5'(i);
        end
      end
    end else if (valid_i) begin
      if (misaligned_fetch_i) begin
        code    = CAUSE_MISALIGNED_FETCH;
        mtval_o = target_address_i;
      end else if (illegal_instruction_i) begin
        code    = CAUSE_ILLEGAL;
        mtval_o = instruction_i;
      end else if (ebreak_i) begin
        code    = CAUSE_EBREAK;
        mtval_o = pc_i;
      end else if (misaligned_load_i) begin
        code    = CAUSE_MISALIGNED_LOAD;
        mtval_o = target_address_i;
      end else if (misaligned_store_i) begin
        code    = CAUSE_MISALIGNED_STORE;
        mtval_o = target_address_i;
      end else if (ecall_i) begin
        code    = CAUSE_ECALL;
      end
    end
    cause_o = {interrupt, 26'd0, code};
  end

endmodule

// File: rtl/rvx_trap_unit.sv
// Trap decision and machine trap CSRs (mstatus MIE/MPIE, mie, mip, mtvec,
// mepc, mcause, mtval) feeding the core state FSM.
// Ports: clock, reset_n (sync, active low), clock_enable (global stall),
//        core_state_s1, stage-1 instruction info and exception flags,
//        mret_s1, level interrupt requests, csr_bus (CSR access slave),
//        take_trap_s1, trap_address_s1, mepc_s1, mstatus_mie.
module rvx_trap_unit
  import rvx_trap_unit_pkg::*;
#(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  clock_enable,
  input  logic [3:0]            core_state_s1,
  input  logic                  valid_s1,
  input  logic [31:0]           pc_s1,
  input  logic [31:0]           instruction_s1,
  input  logic [31:0]           target_address_s1,
  input  logic                  misaligned_fetch_s1,
  input  logic                  illegal_instruction_s1,
  input  logic                  ebreak_s1,
  input  logic                  misaligned_load_s1,
  input  logic                  misaligned_store_s1,
  input  logic                  ecall_s1,
  input  logic                  mret_s1,
  input  logic                  irq_external,
  input  logic                  irq_timer,
  input  logic                  irq_software,
  input  logic [15:0]           irq_fast,
  rvx_trap_unit_if.slave        csr_bus,
  output logic                  take_trap_s1,
  output logic [31:0]           trap_address_s1,
  output logic [31:0]           mepc_s1,
  output logic                  mstatus_mie
);

  logic        mie_bit_q, mie_bit_d;
  logic        mpie_bit_q, mpie_bit_d;
  logic [31:0] mie_q, mie_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] mtval_q, mtval_d;

  logic [31:0] mip;
  logic [31:0] irq_pend;
  logic        operating, int_req, exc_req;
  logic [31:0] trap_cause, trap_mtval;
  logic [31:0] mtvec_base;

  // mip mirrors the request lines directly; nothing is latched.
  assign mip = {irq_fast, 4'b0, irq_external, 3'b0, irq_timer, 3'b0, irq_software, 3'b0};
  assign irq_pend = mip & mie_q;

  assign operating = (core_state_s1 == RVX_STATE_OPERATING);
  assign int_req   = mie_bit_q & (|irq_pend);
  assign exc_req   = valid_s1 & (misaligned_fetch_s1 | illegal_instruction_s1 | ebreak_s1 |
                                 misaligned_load_s1 | misaligned_store_s1 | ecall_s1);
  // Gated by reset_n so no trap request leaks out while the core is held in reset.
  assign take_trap_s1 = reset_n & operating & (int_req | exc_req);

  rvx_trap_unit_priority u_priority (
    .int_req_i            (int_req),
    .irq_external_i       (irq_pend[11]),
    .irq_software_i       (irq_pend[3]),
    .irq_timer_i          (irq_pend[7]),
    .irq_fast_i           (irq_pend[31:16]),
    .valid_i              (valid_s1),
    .misaligned_fetch_i   (misaligned_fetch_s1),
    .illegal_instruction_i(illegal_instruction_s1),
    .ebreak_i             (ebreak_s1),
    .misaligned_load_i    (misaligned_load_s1),
    .misaligned_store_i   (misaligned_store_s1),
    .ecall_i              (ecall_s1),
    .pc_i                 (pc_s1),
    .instruction_i        (instruction_s1),
    .target_address_i     (target_address_s1),
    .cause_o              (trap_cause),
    .mtval_o              (trap_mtval)
  );

  // Vectored mode only applies to interrupts; 4*mcause wraps at 32 bits.
  assign mtvec_base      = {mtvec_q[31:2], 2'b00};
  assign trap_address_s1 = (mtvec_q[0] & mcause_q[31]) ? mtvec_base + {mcause_q[29:0], 2'b00}
                                                       : mtvec_base;
  assign mepc_s1     = mepc_q;
  assign mstatus_mie = mie_bit_q;

  always_comb begin
    csr_bus.csr_read_data = 32'h0;
    case (csr_bus.csr_address)
      CSR_MSTATUS: begin
        csr_bus.csr_read_data                   = 32'h0000_1800;
        csr_bus.csr_read_data[MSTATUS_MIE_BIT]  = mie_bit_q;
        csr_bus.csr_read_data[MSTATUS_MPIE_BIT] = mpie_bit_q;
      end
      CSR_MIE:    csr_bus.csr_read_data = mie_q;
      CSR_MTVEC:  csr_bus.csr_read_data = mtvec_q;
      CSR_MEPC:   csr_bus.csr_read_data = mepc_q;
      CSR_MCAUSE: csr_bus.csr_read_data = mcause_q;
      CSR_MTVAL:  csr_bus.csr_read_data = mtval_q;
      CSR_MIP:    csr_bus.csr_read_data = mip;
      default:    csr_bus.csr_read_data = 32'h0;
    endcase
  end

  // Trap capture beats MRET, which beats a CSR write; the loser is dropped.
  always_comb begin
    mie_bit_d  = mie_bit_q;
    mpie_bit_d = mpie_bit_q;
    mie_d      = mie_q;
    mtvec_d    = mtvec_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    if (clock_enable) begin
      if (take_trap_s1) begin
        mepc_d     = {pc_s1[31:2], 2'b00};
        mcause_d   = trap_cause;
        mtval_d    = trap_mtval;
        mpie_bit_d = mie_bit_q;
        mie_bit_d  = 1'b0;
      end else if (operating && mret_s1) begin
        mie_bit_d  = mpie_bit_q;
        mpie_bit_d = 1'b1;
      end else if (operating && csr_bus.csr_write_enable) begin
        case (csr_bus.csr_address)
          CSR_MSTATUS: begin
            mie_bit_d  = csr_bus.csr_write_data[MSTATUS_MIE_BIT];
            mpie_bit_d = csr_bus.csr_write_data[MSTATUS_MPIE_BIT];
          end
          CSR_MIE:    mie_d    = csr_bus.csr_write_data & MIE_WRITE_MASK;
          CSR_MTVEC:  mtvec_d  = {csr_bus.csr_write_data[31:2], 1'b0, csr_bus.csr_write_data[0]};
          CSR_MEPC:   mepc_d   = {csr_bus.csr_write_data[31:2], 2'b00};
          CSR_MCAUSE: mcause_d = csr_bus.csr_write_data;
          CSR_MTVAL:  mtval_d  = csr_bus.csr_write_data;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      mie_bit_q  <= 1'b0;
      mpie_bit_q <= 1'b0;
      mie_q      <= 32'h0;
      mtvec_q    <= MTVEC_RESET;
      mepc_q     <= 32'h0;
      mcause_q   <= 32'h0;
      mtval_q    <= 32'h0;
    end else begin
      mie_bit_q  <= mie_bit_d;
      mpie_bit_q <= mpie_bit_d;
      mie_q      <= mie_d;
      mtvec_q    <= mtvec_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
    end
  end

endmodule

// File: tb/tb_rvx_trap_unit.sv
module tb_rvx_trap_unit;
  import rvx_trap_unit_pkg::*;

  localparam int S_CSR   = 0;
  localparam int S_TAKE  = 1;
  localparam int S_TADDR = 2;
  localparam int S_MEPC  = 3;
  localparam int S_MIE   = 4;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } sb_item_t;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        clock_enable;
  logic [3:0]  core_state_s1;
  logic        valid_s1;
  logic [31:0] pc_s1, instruction_s1, target_address_s1;
  logic        misaligned_fetch_s1, illegal_instruction_s1, ebreak_s1;
  logic        misaligned_load_s1, misaligned_store_s1, ecall_s1, mret_s1;
  logic        irq_external, irq_timer, irq_software;
  logic [15:0] irq_fast;
  logic        take_trap_s1, mstatus_mie;
  logic [31:0] trap_address_s1, mepc_s1;

  rvx_trap_unit_if bus ();

  rvx_trap_unit #(.MTVEC_RESET(32'h0000_0100)) dut (
    .clock                 (clock),
    .reset_n               (reset_n),
    .clock_enable          (clock_enable),
    .core_state_s1         (core_state_s1),
    .valid_s1              (valid_s1),
    .pc_s1                 (pc_s1),
    .instruction_s1        (instruction_s1),
    .target_address_s1     (target_address_s1),
    .misaligned_fetch_s1   (misaligned_fetch_s1),
    .illegal_instruction_s1(illegal_instruction_s1),
    .ebreak_s1             (ebreak_s1),
    .misaligned_load_s1    (misaligned_load_s1),
    .misaligned_store_s1   (misaligned_store_s1),
    .ecall_s1              (ecall_s1),
    .mret_s1               (mret_s1),
    .irq_external          (irq_external),
    .irq_timer             (irq_timer),
    .irq_software          (irq_software),
    .irq_fast              (irq_fast),
    .csr_bus               (bus),
    .take_trap_s1          (take_trap_s1),
    .trap_address_s1       (trap_address_s1),
    .mepc_s1               (mepc_s1),
    .mstatus_mie           (mstatus_mie)
  );

  always #5 clock = ~clock;

  sb_item_t sb[$];
  int total = 0;
  int bad   = 0;

  // Monitor: one queued expectation is retired per falling edge.
  initial begin : monitor
    sb_item_t    it;
    logic [31:0] act;
    forever begin
      @(negedge clock);
      if (sb.size() > 0) begin
        it = sb.pop_front();
        case (it.sel)
          S_CSR:   act = bus.csr_read_data;
          S_TAKE:  act = {31'd0, take_trap_s1};
          S_TADDR: act = trap_address_s1;
          S_MEPC:  act = mepc_s1;
          default: act = {31'd0, mstatus_mie};
        endcase
        total++;
        if (act !== it.exp) begin
          bad++;
          $display("FAIL %s: got 0x%08h expected 0x%08h", it.tag, act, it.exp);
        end else begin
          $display("ok   %s: 0x%08h", it.tag, act);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input int sel, input logic [11:0] addr, input logic [31:0] exp);
    sb_item_t it;
    if (sel == S_CSR) bus.csr_address = addr;
    it.tag = tag;
    it.sel = sel;
    it.exp = exp;
    sb.push_back(it);
    @(negedge clock);
    #1;
  endtask

  // One enabled clock edge with whatever inputs are currently driven.
  task automatic fire();
    clock_enable = 1'b1;
    @(posedge clock);
    #1;
    clock_enable = 1'b0;
  endtask

  task automatic csr_wr(input logic [11:0] addr, input logic [31:0] data);
    bus.csr_write_enable = 1'b1;
    bus.csr_address      = addr;
    bus.csr_write_data   = data;
    fire();
    bus.csr_write_enable = 1'b0;
  endtask

  task automatic clear_stage();
    valid_s1 = 0; misaligned_fetch_s1 = 0; illegal_instruction_s1 = 0; ebreak_s1 = 0;
    misaligned_load_s1 = 0; misaligned_store_s1 = 0; ecall_s1 = 0; mret_s1 = 0;
    irq_external = 0; irq_timer = 0; irq_software = 0; irq_fast = 16'h0;
  endtask

  task automatic do_mret();
    core_state_s1 = RVX_STATE_OPERATING;
    mret_s1 = 1'b1;
    fire();
    mret_s1 = 1'b0;
  endtask

  initial begin : stimulus
    reset_n = 1'b0; clock_enable = 1'b1; core_state_s1 = RVX_STATE_RESET;
    clear_stage();
    pc_s1 = 0; instruction_s1 = 0; target_address_s1 = 0;
    bus.csr_write_enable = 0; bus.csr_address = 0; bus.csr_write_data = 0;
    irq_external = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_take", S_TAKE, 12'h0, 32'h0);
    reset_n = 1'b1; clock_enable = 1'b0; core_state_s1 = RVX_STATE_OPERATING;
    chk("reset_mtvec", S_CSR, CSR_MTVEC, 32'h0000_0100);
    chk("reset_mstatus", S_CSR, CSR_MSTATUS, 32'h0000_1800);
    chk("reset_mie_out", S_MIE, 12'h0, 32'h0);
    chk("reset_mcause", S_CSR, CSR_MCAUSE, 32'h0);
    chk("mip_external", S_CSR, CSR_MIP, 32'h0000_0800);
    csr_wr(CSR_MIE, 32'h0000_0800);
    chk("mie_ext_write", S_CSR, CSR_MIE, 32'h0000_0800);
    chk("irq_blocked_mie0", S_TAKE, 12'h0, 32'h0);
    irq_external = 1'b0;
    chk("unmapped_csr", S_CSR, 12'h7FF, 32'h0);

    // Illegal instruction with a colliding mepc write.
    valid_s1 = 1; illegal_instruction_s1 = 1; pc_s1 = 32'h200; instruction_s1 = 32'hFFFF_FFFF;
    bus.csr_write_enable = 1; bus.csr_address = CSR_MEPC; bus.csr_write_data = 32'h1234;
    chk("illegal_take", S_TAKE, 12'h0, 32'h1);
    fire();
    bus.csr_write_enable = 0;
    core_state_s1 = RVX_STATE_TRAP_TAKEN;
    chk("no_take_trap_taken", S_TAKE, 12'h0, 32'h0);
    chk("illegal_mepc", S_CSR, CSR_MEPC, 32'h200);
    chk("illegal_mcause", S_CSR, CSR_MCAUSE, 32'h2);
    chk("illegal_mtval", S_CSR, CSR_MTVAL, 32'hFFFF_FFFF);
    chk("illegal_taddr", S_TADDR, 12'h0, 32'h100);
    clear_stage();

    // Stalled: a pending CSR write must not land.
    core_state_s1 = RVX_STATE_OPERATING;
    bus.csr_write_enable = 1; bus.csr_address = CSR_MTVAL; bus.csr_write_data = 32'h5555;
    repeat (3) @(posedge clock);
    #1;
    bus.csr_write_enable = 0;
    chk("hold_mtval", S_CSR, CSR_MTVAL, 32'hFFFF_FFFF);
    valid_s1 = 1; ebreak_s1 = 1; pc_s1 = 32'h300;
    repeat (3) @(posedge clock);
    #1;
    chk("hold_take_comb", S_TAKE, 12'h0, 32'h1);
    chk("hold_mepc", S_CSR, CSR_MEPC, 32'h200);
    fire();
    core_state_s1 = RVX_STATE_TRAP_TAKEN;
    chk("ebreak_mcause", S_CSR, CSR_MCAUSE, 32'h3);
    chk("ebreak_mtval", S_CSR, CSR_MTVAL, 32'h300);
    clear_stage();

    // Load beats store; mepc alignment.
    core_state_s1 = RVX_STATE_OPERATING;
    valid_s1 = 1; misaligned_load_s1 = 1; misaligned_store_s1 = 1;
    pc_s1 = 32'h402; target_address_s1 = 32'h1001;
    fire();
    core_state_s1 = RVX_STATE_TRAP_TAKEN;
    chk("load_mcause", S_CSR, CSR_MCAUSE, 32'h4);
    chk("load_mtval", S_CSR, CSR_MTVAL, 32'h1001);
    chk("load_mepc", S_CSR, CSR_MEPC, 32'h400);
    clear_stage();

    // CSR write masks, then a vectored timer interrupt.
    core_state_s1 = RVX_STATE_OPERATING;
    csr_wr(CSR_MTVEC, 32'h103);
    chk("mtvec_bit1", S_CSR, CSR_MTVEC, 32'h101);
    csr_wr(CSR_MIE, 32'hFFFF_FFFF);
    chk("mie_mask", S_CSR, CSR_MIE, 32'hFFFF_0888);
    csr_wr(CSR_MSTATUS, 32'hFFFF_FFFF);
    chk("mstatus_mask", S_CSR, CSR_MSTATUS, 32'h0000_1888);
    csr_wr(CSR_MIE, 32'h80);
    csr_wr(CSR_MSTATUS, 32'h8);
    chk("mstatus_mie_only", S_CSR, CSR_MSTATUS, 32'h0000_1808);
    irq_timer = 1;
    chk("timer_take", S_TAKE, 12'h0, 32'h1);
    fire();
    core_state_s1 = RVX_STATE_TRAP_TAKEN;
    chk("timer_mcause", S_CSR, CSR_MCAUSE, 32'h8000_0007);
    chk("timer_mtval", S_CSR, CSR_MTVAL, 32'h0);
    chk("timer_taddr", S_TADDR, 12'h0, 32'h11C);
    chk("timer_mstatus", S_CSR, CSR_MSTATUS, 32'h0000_1880);
    chk("timer_mie_out", S_MIE, 12'h0, 32'h0);
    core_state_s1 = RVX_STATE_OPERATING;
    chk("timer_masked", S_TAKE, 12'h0, 32'h0);

    // MRET with a colliding mtval write.
    mret_s1 = 1;
    bus.csr_write_enable = 1; bus.csr_address = CSR_MTVAL; bus.csr_write_data = 32'hAAAA;
    fire();
    mret_s1 = 0; bus.csr_write_enable = 0;
    core_state_s1 = RVX_STATE_TRAP_RETURN;
    chk("no_take_trap_return", S_TAKE, 12'h0, 32'h0);
    chk("mret_mepc_out", S_MEPC, 12'h0, 32'h400);
    chk("mret_mstatus", S_CSR, CSR_MSTATUS, 32'h0000_1888);
    chk("mret_mtval_drop", S_CSR, CSR_MTVAL, 32'h0);
    clear_stage();

    // Interrupts beat exceptions; external is highest.
    core_state_s1 = RVX_STATE_OPERATING;
    csr_wr(CSR_MIE, 32'hFFFF_FFFF);
    irq_external = 1; irq_timer = 1; irq_fast = 16'h0004; valid_s1 = 1; ecall_s1 = 1; pc_s1 = 32'h500;
    fire();
    core_state_s1 = RVX_STATE_TRAP_TAKEN;
    chk("prio_mcause", S_CSR, CSR_MCAUSE, 32'h8000_000B);
    chk("prio_mtval", S_CSR, CSR_MTVAL, 32'h0);
    chk("prio_mepc", S_CSR, CSR_MEPC, 32'h500);
    chk("prio_taddr", S_TADDR, 12'h0, 32'h12C);
    clear_stage();
    do_mret();

    // Fast interrupts: lowest index first.
    irq_fast = 16'h0014;
    chk("mip_fast", S_CSR, CSR_MIP, 32'h0014_0000);
    fire();
    core_state_s1 = RVX_STATE_TRAP_TAKEN;
    chk("fast_mcause", S_CSR, CSR_MCAUSE, 32'h8000_0012);
    chk("fast_taddr", S_TADDR, 12'h0, 32'h148);
    clear_stage();
    do_mret();

    irq_software = 1; irq_timer = 1;
    fire();
    chk("sw_mcause", S_CSR, CSR_MCAUSE, 32'h8000_0003);
    clear_stage();
    do_mret();

    // Exception in vectored mode still uses the base.
    valid_s1 = 1; ecall_s1 = 1; pc_s1 = 32'h600; target_address_s1 = 32'hDEAD;
    fire();
    core_state_s1 = RVX_STATE_TRAP_TAKEN;
    chk("ecall_mcause", S_CSR, CSR_MCAUSE, 32'hB);
    chk("ecall_mtval", S_CSR, CSR_MTVAL, 32'h0);
    chk("ecall_taddr", S_TADDR, 12'h0, 32'h100);
    clear_stage();

    // Reset while in a trap.
    reset_n = 1'b0;
    fire();
    reset_n = 1'b1;
    chk("rst2_mcause", S_CSR, CSR_MCAUSE, 32'h0);
    chk("rst2_mepc", S_CSR, CSR_MEPC, 32'h0);
    chk("rst2_mtvec", S_CSR, CSR_MTVEC, 32'h100);
    chk("rst2_mstatus", S_CSR, CSR_MSTATUS, 32'h0000_1800);
    chk("rst2_mie", S_CSR, CSR_MIE, 32'h0);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clock);
    #1;
    if (sb.size() > 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expected 0 pending", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rvx_trap_unit.md
Name: rvx_trap_unit

Overview:
- Trap-decision and machine-trap CSR block that sits directly upstream of the core state FSM.
- Merges stage-1 synchronous exceptions with enabled, pending interrupts and produces take_trap_s1. The FSM consumes take_trap_s1 and, separately, mret_s1.
- Holds mstatus.MIE/MPIE, mie, mtvec, mepc, mcause and mtval.
- Supplies the fetch logic with the trap target address and the return address while the FSM is in TRAP_TAKEN or TRAP_RETURN.

Parameters:
- MTVEC_RESET, 32'h0000_0000, reset value of mtvec; bits [1:0] must be 2'b00 or 2'b01.

Ports:
- clock  in  1  clock
- reset_n  in  1  synchronous active-low reset
- clock_enable  in  1  global stall; no state update when low
- core_state_s1  in  4  current core FSM state, encoded with RVX_STATE_* from rvx_constants.vh
- valid_s1  in  1  stage-1 instruction is valid
- pc_s1  in  32  PC of the stage-1 instruction
- instruction_s1  in  32  raw stage-1 instruction
- target_address_s1  in  32  fetch target or load/store address
- misaligned_fetch_s1, illegal_instruction_s1, ebreak_s1, misaligned_load_s1, misaligned_store_s1, ecall_s1  in  1 each  exception flags
- mret_s1  in  1  stage-1 instruction is MRET
- irq_external, irq_timer, irq_software  in  1 each  level interrupt requests
- irq_fast  in  16  level fast interrupt requests
- csr_write_enable  in  1  CSR write strobe
- csr_address  in  12  CSR address
- csr_write_data  in  32  CSR write data
- csr_read_data  out  32  combinational read of the addressed CSR; 0 if unmapped
- take_trap_s1  out  1  trap request to the core FSM
- trap_address_s1  out  32  trap target, valid in TRAP_TAKEN
- mepc_s1  out  32  return address, valid in TRAP_RETURN
- mstatus_mie  out  1  global interrupt enable

Behaviour:
- Reset values: MIE=0, MPIE=0, mie=0, mtvec=MTVEC_RESET, mepc=0, mcause=0, mtval=0.
- Outputs after reset follow these register values; take_trap_s1 is 0 during reset.
- mip (read-only) is built combinationally from the request lines: bit3 = software, bit7 = timer, bit11 = external, bits[31:16] = irq_fast. Nothing is latched.
- int_req = MIE & |(mip & mie).
- exc_req = valid_s1 & OR of the six exception flags.
- take_trap_s1 = (core_state_s1 == RVX_STATE_OPERATING) & (int_req | exc_req). This output is combinational.
- Interrupt priority (interrupts beat exceptions):
  - external, cause 11;
  - software, cause 3;
  - timer, cause 7;
  - irq_fast[i], cause 16+i, lowest i first.
  - mcause[31] = 1 for interrupts.
- Exception priority:
  - misaligned fetch, cause 0;
  - illegal, cause 2;
  - ebreak, cause 3;
  - misaligned load, cause 4;
  - misaligned store, cause 6;
  - ecall, cause 11.
- mtval on an interrupt: 0.
- mtval on an exception:
  - misaligned fetch, load or store: target_address_s1;
  - illegal: instruction_s1;
  - ebreak: pc_s1;
  - ecall: 0.
- Trap capture happens on the edge where clock_enable & take_trap_s1. This is the same edge on which the FSM enters TRAP_TAKEN. At that edge:
  - mepc <= {pc_s1[31:2], 2'b00};
  - mcause and mtval are written as above;
  - MPIE <= MIE and MIE <= 0.
- MRET: on the edge where clock_enable & OPERATING & mret_s1 & !take_trap_s1, MIE <= MPIE and MPIE <= 1.
- trap_address_s1:
  - {mtvec[31:2], 2'b00} when mtvec[0] = 0, or when mcause[31] = 0;
  - {mtvec[31:2], 2'b00} + 4*mcause[4:0]... more precisely, base + 4*mcause[30:0] when mtvec[0] = 1 and mcause[31] = 1 (vectored mode).
- mepc_s1 = mepc.
- CSR writes take effect on clock_enable & csr_write_enable & OPERATING & !take_trap_s1. A trap capture or MRET update wins over a CSR write in the same cycle; the write is dropped. Per-CSR write rules:
  - mstatus 0x300: only bits 3 and 7 are writable; reads return MPP = 2'b11 in bits [12:11].
  - mie 0x304: bits 3, 7, 11 and [31:16] writable; all other bits read 0.
  - mtvec 0x305: bit1 is forced to 0.
  - mepc 0x341: bits [1:0] are forced to 0.
  - mcause 0x342: fully writable.
  - mtval 0x343: fully writable.
  - mip 0x344: read-only.
- States TRAP_TAKEN, TRAP_RETURN and RESET: take_trap_s1 = 0 and no CSR writes. Interrupts pending in these states are taken in the next OPERATING cycle.
- clock_enable low: all registers hold. take_trap_s1 still reflects its inputs combinationally.
- Reset asserted mid-trap: every register returns to its reset value on the next edge.

Decomposition:
- rvx_constants.vh holds:
  - RVX_STATE_* encodings;
  - CSR address constants;
  - cause codes (exceptions and interrupts);
  - mstatus bit indices.
- A natural sub-module is rvx_trap_priority: a combinational priority encoder producing cause, interrupt flag and mtval selection. The register and CSR logic stays in the top module.

Test Plan:
- Reset with MTVEC_RESET = 32'h0000_0100 -> csr_read_data for mtvec reads 0x100; MIE = 0; take_trap_s1 = 0 even with irq_external = 1 and mie[11] = 1.
- OPERATING, valid_s1 = 1, illegal_instruction_s1 = 1, pc_s1 = 0x200, instruction_s1 = 0xFFFF_FFFF -> take_trap_s1 = 1. After the edge: mepc = 0x200, mcause = 2, mtval = 0xFFFF_FFFF; trap_address_s1 = 0x100 in TRAP_TAKEN.
- Write mtvec = 0x101 and mie bit 7, set MIE; assert irq_timer -> trap. mcause = 0x8000_0007, trap_address_s1 = 0x11C, MIE = 0, MPIE = 1.
- Assert irq_external, irq_timer and irq_fast[2] together with ecall_s1 -> mcause = 0x8000_000B and mtval = 0.
- mret_s1 in OPERATING with MPIE = 1 and MIE = 0 -> after the edge MIE = 1 and MPIE = 1; mepc_s1 = mepc in TRAP_RETURN.
- A CSR write to mepc in the same cycle as a trap -> mepc = pc_s1 (write dropped). With clock_enable = 0 for 3 cycles, all registers hold.
